// File: rtl/load_port_arbiter.sv
// load_port_arbiter
// Shares one synchronous-read memory (1-cycle read latency) between two load
// ports. Address requests are arbitrated round-robin; each port keeps at most
// one read in flight and owns a 1-entry response buffer, so either consumer
// can back-pressure without stalling the other port.
//
// Build option: define ARB_FIXED_PRIO_EN to resolve ties always in favour of
// port 0 (port 1 may starve). Default build is round-robin.
module load_port_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic              req0_addr_valid,
    output logic              req0_addr_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_data_valid,
    input  logic              rsp0_data_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req1_addr_valid,
    output logic              req1_addr_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_data_valid,
    input  logic              rsp1_data_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    logic              inflight0;
    logic              inflight1;
    logic              rbuf_valid0;
    logic              rbuf_valid1;
    logic [DATA_W-1:0] rbuf0;
    logic [DATA_W-1:0] rbuf1;
    logic              elig0;
    logic              elig1;
    logic              grant0;
    logic              grant1;
`ifndef ARB_FIXED_PRIO_EN
    logic              last_grant;
`endif

    // Eligibility and single-winner grant; reset held low suppresses all grants.
    always_comb begin
        elig0  = reset & req0_addr_valid & ~inflight0 & (~rbuf_valid0 | rsp0_data_ready);
        elig1  = reset & req1_addr_valid & ~inflight1 & (~rbuf_valid1 | rsp1_data_ready);
        grant0 = elig0;
        grant1 = elig1;
        if (elig0 && elig1) begin
`ifdef ARB_FIXED_PRIO_EN
            grant1 = 1'b0;
`else
            // last_grant==1 means port 1 won most recently, so port 0 goes now
            grant0 = last_grant;
            grant1 = ~last_grant;
`endif
        end
    end

    assign req0_addr_ready = grant0;
    assign req1_addr_ready = grant1;
    assign mem_en          = grant0 | grant1;
    assign mem_addr        = grant0 ? req0_addr : (grant1 ? req1_addr : '0);
    assign rsp0_data       = rbuf0;
    assign rsp0_data_valid = rbuf_valid0;
    assign rsp1_data       = rbuf1;
    assign rsp1_data_valid = rbuf_valid1;
    assign busy            = inflight0 | inflight1 | rbuf_valid0 | rbuf_valid1;

    // Port 0 in-flight flag and response buffer.
    // A read is in flight exactly the cycle after its grant, so the flag is
    // just the registered grant; capture wins over a same-cycle drain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight0   <= 1'b0;
            rbuf_valid0 <= 1'b0;
            rbuf0       <= '0;
        end else begin
            inflight0 <= grant0;
            if (inflight0) begin
                rbuf0       <= mem_rdata;
                rbuf_valid0 <= 1'b1;
            end else if (rsp0_data_ready) begin
                rbuf_valid0 <= 1'b0;
            end
        end
    end

    // Port 1 in-flight flag and response buffer (same scheme as port 0).
    always_ff @(posedge clock) begin
        if (!reset) begin
            inflight1   <= 1'b0;
            rbuf_valid1 <= 1'b0;
            rbuf1       <= '0;
        end else begin
            inflight1 <= grant1;
            if (inflight1) begin
                rbuf1       <= mem_rdata;
                rbuf_valid1 <= 1'b1;
            end else if (rsp1_data_ready) begin
                rbuf_valid1 <= 1'b0;
            end
        end
    end

`ifndef ARB_FIXED_PRIO_EN
    // Round-robin history: remembers which port won the most recent grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_load_port_arbiter.sv
// Testbench for load_port_arbiter: directed vector table, hand-written
// corner-case sequences, and randomized traffic checked against a
// transaction-level reference model (per-port queues of time-stamped reads).
module tb_load_port_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req0_addr;
    logic        req0_addr_valid;
    logic        req0_addr_ready;
    logic [31:0] rsp0_data;
    logic        rsp0_data_valid;
    logic        rsp0_data_ready;
    logic [3:0]  req1_addr;
    logic        req1_addr_valid;
    logic        req1_addr_ready;
    logic [31:0] rsp1_data;
    logic        rsp1_data_valid;
    logic        rsp1_data_ready;
    logic [3:0]  mem_addr;
    logic        mem_en;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] mem [0:15];

    load_port_arbiter #(.ADDR_W(4), .DATA_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .req0_addr       (req0_addr),
        .req0_addr_valid (req0_addr_valid),
        .req0_addr_ready (req0_addr_ready),
        .rsp0_data       (rsp0_data),
        .rsp0_data_valid (rsp0_data_valid),
        .rsp0_data_ready (rsp0_data_ready),
        .req1_addr       (req1_addr),
        .req1_addr_valid (req1_addr_valid),
        .req1_addr_ready (req1_addr_ready),
        .rsp1_data       (rsp1_data),
        .rsp1_data_valid (rsp1_data_valid),
        .rsp1_data_ready (rsp1_data_ready),
        .mem_addr        (mem_addr),
        .mem_en          (mem_en),
        .mem_rdata       (mem_rdata),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous-read memory, one cycle latency
    always @(posedge clock) begin
        if (mem_en) mem_rdata <= mem[mem_addr];
    end

    // reference model: each outstanding read is a record stamped with its grant cycle
    typedef struct {
        logic [31:0] data;
        int          g;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   cyc;
    int   lw;
    int   n_pass;
    int   n_total;
    logic e_g0;
    logic e_g1;

    typedef struct {
        int v0, a0, r0, v1, a1, r1;
        int g0, g1, maddr, dv0, d0, dv1, d1, bsy;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    endtask

    task automatic set_in(input int v0, input int a0, input int r0,
                          input int v1, input int a1, input int r1);
        req0_addr_valid = (v0 != 0);
        req0_addr       = a0[3:0];
        rsp0_data_ready = (r0 != 0);
        req1_addr_valid = (v1 != 0);
        req1_addr       = a1[3:0];
        rsp1_data_ready = (r1 != 0);
    endtask

    // Compare DUT against the model for the current cycle, then advance one clock.
    task automatic step();
        logic       inf0, inf1, rb0, rb1, el0, el1, tie0;
        logic [3:0] ea;
        #1;
        inf0 = (q0.size() > 0) && (q0[q0.size()-1].g == cyc - 1);
        inf1 = (q1.size() > 0) && (q1[q1.size()-1].g == cyc - 1);
        rb0  = (q0.size() > 0) && (q0[0].g <= cyc - 2);
        rb1  = (q1.size() > 0) && (q1[0].g <= cyc - 2);
        el0  = reset && req0_addr_valid && !inf0 && (!rb0 || rsp0_data_ready);
        el1  = reset && req1_addr_valid && !inf1 && (!rb1 || rsp1_data_ready);
`ifdef ARB_FIXED_PRIO_EN
        tie0 = 1'b1;
`else
        tie0 = (lw == 1);
`endif
        e_g0 = el0 && (!el1 || tie0);
        e_g1 = el1 && !e_g0;
        ea   = e_g0 ? req0_addr : (e_g1 ? req1_addr : 4'd0);
        chk("model_grant0", 32'(req0_addr_ready), 32'(e_g0));
        chk("model_grant1", 32'(req1_addr_ready), 32'(e_g1));
        chk("model_mem_en", 32'(mem_en), 32'(e_g0 | e_g1));
        chk("model_mem_addr", 32'(mem_addr), 32'(ea));
        chk("model_rsp0_valid", 32'(rsp0_data_valid), 32'(rb0));
        chk("model_rsp1_valid", 32'(rsp1_data_valid), 32'(rb1));
        if (rb0) chk("model_rsp0_data", rsp0_data, q0[0].data);
        if (rb1) chk("model_rsp1_data", rsp1_data, q1[0].data);
        chk("model_busy", 32'(busy), 32'(inf0 | inf1 | rb0 | rb1));
        @(posedge clock);
        if (!reset) begin
            q0.delete();
            q1.delete();
            lw = 1;
        end else begin
            if (rb0 && rsp0_data_ready) void'(q0.pop_front());
            if (rb1 && rsp1_data_ready) void'(q1.pop_front());
            if (e_g0) begin
                q0.push_back('{mem[req0_addr], cyc});
                lw = 0;
            end
            if (e_g1) begin
                q1.push_back('{mem[req1_addr], cyc});
                lw = 1;
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1, n, men_cnt, rcv0, rcv1, cnt0, stall0, stall1, rst_cnt;
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        lw      = 1;
        for (int unsigned i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + i;
        mem[3] = 32'hDEAD_BEEF;

        //          v0 a0 r0 v1 a1 r1  g0 g1 ma  dv0 d0            dv1 d1             busy
        tbl[0]  = '{1, 3, 1, 0, 0, 1,  1, 0, 3,  0, 0,             0, 0,              0};
        tbl[1]  = '{1, 5, 1, 0, 0, 1,  0, 0, 0,  0, 0,             0, 0,              1};
        tbl[2]  = '{1, 5, 1, 0, 0, 1,  1, 0, 5,  1, int'(mem[3]),  0, 0,              1};
        tbl[3]  = '{0, 0, 1, 1, 2, 1,  0, 1, 2,  0, 0,             0, 0,              1};
        tbl[4]  = '{1, 1, 1, 1, 4, 1,  1, 0, 1,  1, int'(mem[5]),  0, 0,              1};
        tbl[5]  = '{1, 6, 1, 1, 4, 0,  0, 0, 0,  0, 0,             1, int'(mem[2]),   1};
        tbl[6]  = '{1, 6, 1, 1, 4, 0,  1, 0, 6,  1, int'(mem[1]),  1, int'(mem[2]),   1};
        tbl[7]  = '{0, 0, 1, 1, 4, 1,  0, 1, 4,  0, 0,             1, int'(mem[2]),   1};
        tbl[8]  = '{0, 0, 1, 0, 0, 1,  0, 0, 0,  1, int'(mem[6]),  0, 0,              1};
        tbl[9]  = '{0, 0, 1, 0, 0, 1,  0, 0, 0,  0, 0,             1, int'(mem[4]),   1};
        tbl[10] = '{0, 0, 1, 0, 0, 1,  0, 0, 0,  0, 0,             0, 0,              0};
        tbl[11] = '{1, 7, 1, 1, 8, 1,  1, 0, 7,  0, 0,             0, 0,              0};
        tbl[12] = '{1, 7, 1, 1, 8, 1,  0, 1, 8,  0, 0,             0, 0,              1};
        tbl[13] = '{1, 9, 1, 1, 8, 1,  1, 0, 9,  1, int'(mem[7]),  0, 0,              1};
        tbl[14] = '{0, 0, 1, 1, 10, 1, 0, 1, 10, 0, 0,             1, int'(mem[8]),   1};
        tbl[15] = '{0, 0, 1, 0, 0, 1,  0, 0, 0,  1, int'(mem[9]),  0, 0,              1};
        tbl[16] = '{0, 0, 1, 0, 0, 1,  0, 0, 0,  0, 0,             1, int'(mem[10]),  1};
        tbl[17] = '{0, 0, 1, 0, 0, 1,  0, 0, 0,  0, 0,             0, 0,              0};

        // reset held with all valids high: everything quiet
        reset = 1'b0;
        set_in(1, 3, 1, 1, 5, 1);
        @(posedge clock);
        cyc++;
        @(negedge clock);
        repeat (3) begin
            #1;
            chk("rst_grant0", 32'(req0_addr_ready), 0);
            chk("rst_grant1", 32'(req1_addr_ready), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_rsp0_valid", 32'(rsp0_data_valid), 0);
            chk("rst_rsp1_valid", 32'(rsp1_data_valid), 0);
            chk("rst_rsp0_data", rsp0_data, 0);
            chk("rst_rsp1_data", rsp1_data, 0);
            chk("rst_busy", 32'(busy), 0);
            step();
        end
        reset = 1'b1;
        #1;
        chk("rel_first_grant0", 32'(req0_addr_ready), 1);
        chk("rel_first_grant1", 32'(req1_addr_ready), 0);
        step();
        set_in(0, 0, 1, 0, 0, 1);
        repeat (4) step();
        reset = 1'b0;
        step();
        reset = 1'b1;

        // directed vector table starting from a fresh reset
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].v0, tbl[i].a0, tbl[i].r0, tbl[i].v1, tbl[i].a1, tbl[i].r1);
            #1;
            chk("tbl_grant0", 32'(req0_addr_ready), tbl[i].g0);
            chk("tbl_grant1", 32'(req1_addr_ready), tbl[i].g1);
            chk("tbl_mem_en", 32'(mem_en), tbl[i].g0 | tbl[i].g1);
            chk("tbl_mem_addr", 32'(mem_addr), tbl[i].maddr);
            chk("tbl_rsp0_valid", 32'(rsp0_data_valid), tbl[i].dv0);
            chk("tbl_rsp1_valid", 32'(rsp1_data_valid), tbl[i].dv1);
            if (tbl[i].dv0 != 0) chk("tbl_rsp0_data", rsp0_data, tbl[i].d0);
            if (tbl[i].dv1 != 0) chk("tbl_rsp1_data", rsp1_data, tbl[i].d1);
            chk("tbl_busy", 32'(busy), tbl[i].bsy);
            step();
        end

        // both ports streaming addresses 0..7: one grant per cycle, alternating
        i0 = 0; i1 = 0; n = 0; men_cnt = 0; rcv0 = 0; rcv1 = 0;
        while ((i0 < 8 || i1 < 8) && n < 40) begin
            set_in((i0 < 8) ? 1 : 0, i0, 1, (i1 < 8) ? 1 : 0, i1, 1);
            #1;
            if (req0_addr_ready) i0++;
            if (req1_addr_ready) i1++;
            if (mem_en) men_cnt++;
            if (rsp0_data_valid) rcv0++;
            if (rsp1_data_valid) rcv1++;
            n++;
            step();
        end
        set_in(0, 0, 1, 0, 0, 1);
        repeat (3) begin
            #1;
            if (rsp0_data_valid) rcv0++;
            if (rsp1_data_valid) rcv1++;
            step();
        end
        chk("stream_cycles", n, 16);
        chk("stream_mem_en_cycles", men_cnt, 16);
        chk("stream_rsp0_count", rcv0, 8);
        chk("stream_rsp1_count", rcv1, 8);

        // port 1 consumer stalls for 10 cycles; port 0 keeps full service
        set_in(0, 0, 1, 1, 12, 0);
        step();
        set_in(1, 0, 1, 0, 0, 0);
        step();
        cnt0 = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(1, i + 1, 1, 1, 13, 0);
            #1;
            chk("stall_rsp1_valid", 32'(rsp1_data_valid), 1);
            chk("stall_rsp1_data", rsp1_data, mem[12]);
            chk("stall_no_grant1", 32'(req1_addr_ready), 0);
            if (req0_addr_ready) cnt0++;
            step();
        end
        chk("stall_port0_grants", cnt0, 5);
        set_in(0, 0, 1, 0, 0, 1);
        #1;
        chk("stall_release_valid", 32'(rsp1_data_valid), 1);
        step();
        #1;
        chk("stall_no_duplicate", 32'(rsp1_data_valid), 0);
        step();

        // reset the cycle after a grant: the read is dropped
        set_in(1, 2, 1, 0, 0, 1);
        step();
        reset = 1'b0;
        set_in(0, 0, 1, 0, 0, 1);
        step();
        reset = 1'b1;
        repeat (3) begin
            #1;
            chk("midrst_rsp0_valid", 32'(rsp0_data_valid), 0);
            chk("midrst_rsp1_valid", 32'(rsp1_data_valid), 0);
            chk("midrst_busy", 32'(busy), 0);
            step();
        end

        // randomized traffic with consumer stalls and occasional resets
        stall0 = 0; stall1 = 0; rst_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            req0_addr_valid = ($urandom_range(0, 9) < 7);
            req1_addr_valid = ($urandom_range(0, 9) < 7);
            req0_addr       = 4'($urandom_range(0, 15));
            req1_addr       = 4'($urandom_range(0, 15));
            if (stall0 > 0) begin
                rsp0_data_ready = 1'b0;
                stall0--;
            end else if ($urandom_range(0, 19) == 0) begin
                rsp0_data_ready = 1'b0;
                stall0 = int'($urandom_range(1, 15));
            end else begin
                rsp0_data_ready = ($urandom_range(0, 3) != 0);
            end
            if (stall1 > 0) begin
                rsp1_data_ready = 1'b0;
                stall1--;
            end else if ($urandom_range(0, 19) == 0) begin
                rsp1_data_ready = 1'b0;
                stall1 = int'($urandom_range(1, 15));
            end else begin
                rsp1_data_ready = ($urandom_range(0, 3) != 0);
            end
            if (rst_cnt > 0) begin
                reset = 1'b0;
                rst_cnt--;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b0;
                rst_cnt = int'($urandom_range(0, 1));
            end else begin
                reset = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
